// File: rtl/pot_weight_feeder_pkg.sv
// Shared constants for the power-of-two weight feeder: code field layout,
// zero code, shift limit and the sequencer state encoding.
package pot_pkg;

  localparam int WEIGHT_W  = 8;
  localparam int CODE_W    = 8;
  localparam int SIGN_BIT  = 7;
  localparam int ZERO_BIT  = 4;
  localparam int SHIFT_LSB = 0;
  localparam int SHIFT_W   = 4;
  localparam int MAX_SHIFT = 6;

  localparam logic [CODE_W-1:0] ZERO_CODE = CODE_W'(1) << ZERO_BIT;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } fsm_state_e;

  // Assemble a non-zero code: sign on top, zero flag clear, shift in the low nibble.
  function automatic logic [CODE_W-1:0] pack_code(input logic sign,
                                                  input logic [SHIFT_W-1:0] shift);
    logic [CODE_W-1:0] c;
    c = '0;
    c[SIGN_BIT] = sign;
    c[SHIFT_LSB +: SHIFT_W] = shift;
    return c;
  endfunction

endpackage

// File: rtl/pot_weight_feeder_if.sv
// Row-input handshake: one row of signed 8-bit weights per accepted beat.
interface pot_weight_feeder_if
#(
  parameter int COLS = 4
) ();
  import pot_pkg::*;

  logic                       in_valid;
  logic                       in_ready;
  logic [WEIGHT_W*COLS-1:0]   in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/pot_weight_feeder_quant.sv
// Quantises one signed weight to the nearest power of two and packs the
// sign / zero-flag / shift code consumed by a MAC column.
module pot_quant
#(
  parameter int SHIFT_LIMIT = pot_pkg::MAX_SHIFT
) (
  input  logic [7:0] weight,
  output logic [7:0] code
);
  import pot_pkg::*;

  logic [7:0] mag;
  logic [2:0] lead;
  logic [3:0] shift;

  // Magnitude, leading-one search, round up on the next bit down, clamp.
  always_comb begin
    mag   = weight[7] ? (~weight + 8'd1) : weight;
    lead  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (mag[i]) lead = 3'(i);
    end
    shift = {1'b0, lead};
    if ((lead != 3'd0) && mag[lead - 3'd1]) shift = shift + 4'd1;
    if (shift > 4'(SHIFT_LIMIT)) shift = 4'(SHIFT_LIMIT);
    if (mag == 8'd0) code = ZERO_CODE;
    else             code = pack_code(weight[7], shift);
  end

endmodule

// File: rtl/pot_weight_feeder.sv
// Weight feeder for a systolic array: quantises rows into a small FIFO and
// streams a requested number of rows out with a one-cycle-per-column skew.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for start; FIFO may still be filled
//   ST_STREAM | popping one row per cycle when available (bubble otherwise)
//   ST_DRAIN  | last row popped; waiting for it to clear the final column
module pot_weight_feeder
#(
  parameter int COLS      = 4,
  parameter int DEPTH     = 4,
  parameter int MAX_SHIFT = pot_pkg::MAX_SHIFT
) (
  input  logic                  clk,
  input  logic                  reset,
  pot_weight_feeder_if.slave    in_bus,
  input  logic                  start,
  input  logic [7:0]            row_count,
  output logic [8*COLS-1:0]     up_out,
  output logic [COLS-1:0]       col_valid,
  output logic                  busy,
  output logic                  done
);
  import pot_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DRN_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = CODE_W * COLS;

  logic [ROW_W-1:0] wr_codes;
  logic [ROW_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             full, empty, push, pop;

  fsm_state_e       state_q, state_d;
  logic [7:0]       rows_q, rows_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic             done_q, done_d;

  logic [ROW_W-1:0] stg_code [COLS];
  logic [COLS-1:0]  stg_v;

  for (genvar g = 0; g < COLS; g++) begin : g_quant
    pot_quant #(.SHIFT_LIMIT(MAX_SHIFT)) u_quant (
      .weight (in_bus.in_data[WEIGHT_W*g +: WEIGHT_W]),
      .code   (wr_codes[CODE_W*g +: CODE_W])
    );
  end

  assign full            = (fifo_cnt == CNT_W'(DEPTH));
  assign empty           = (fifo_cnt == '0);
  assign in_bus.in_ready = !full;
  assign push            = in_bus.in_valid && !full;
  assign pop             = (state_q == ST_STREAM) && !empty;

  // Row storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wr_codes;
  end

  // FIFO pointers wrap naturally at DEPTH; occupancy tracks push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Sequencer state, remaining-row and drain down-counters, done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rows_q  <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; the drain timer covers the cycles the last row spends
  // walking across columns 0..COLS-1, so done lands as it leaves the last one.
  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (row_count != 8'd0) begin
            state_d = ST_STREAM;
            rows_d  = row_count;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (pop) begin
          rows_d = rows_q - 8'd1;
          if (rows_q == 8'd1) begin
            state_d = ST_DRAIN;
            drain_d = DRN_W'(COLS - 1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - DRN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Skew pipeline: stage k holds the row popped k+1 cycles ago.
  always_ff @(posedge clk) begin
    if (reset) begin
      stg_v <= '0;
      for (int k = 0; k < COLS; k++) stg_code[k] <= {COLS{ZERO_CODE}};
    end else begin
      stg_v[0]    <= pop;
      stg_code[0] <= pop ? fifo_mem[rd_ptr] : {COLS{ZERO_CODE}};
      for (int k = 1; k < COLS; k++) begin
        stg_v[k]    <= stg_v[k-1];
        stg_code[k] <= stg_code[k-1];
      end
    end
  end

  // Column c taps its own slice from stage c; bubbles present the zero code.
  always_comb begin
    up_out    = '0;
    col_valid = '0;
    for (int c = 0; c < COLS; c++) begin
      col_valid[c] = stg_v[c];
      up_out[CODE_W*c +: CODE_W] = stg_v[c] ? stg_code[c][CODE_W*c +: CODE_W] : ZERO_CODE;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule
